// File: rtl/halt_controller.sv
// halt_controller: CPU clock-gate halt control for bus stalls, debug halt, EBREAK and optional single-step (`HALT_STEP_EN`).
// Latency: halt/halted/mem_wait are decoded from state, so they change exactly 1 clk after the causing input.
// Backpressure: none upstream; mem_ack ends a bus stall, and a missing ack is abandoned after TIMEOUT_CYCLES with bus_error.
module halt_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STEP_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume,
  input  logic              dbg_step,
  input  logic [STEP_W-1:0] dbg_step_count,
  input  logic              ebreak,
  output logic              halt,
  output logic              halted,
  output logic              mem_wait,
  output logic              bus_error,
  output logic [1:0]        halt_cause
);

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_MEM    = 2'b01;
  localparam logic [1:0] CAUSE_DEBUG  = 2'b10;
  localparam logic [1:0] CAUSE_EBREAK = 2'b11;

  // Last wait count value before an unacknowledged access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DBG_HALT = 2'd2
`ifdef HALT_STEP_EN
    ,
    STEP     = 2'd3
`endif
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       pend;
  logic [1:0] pend_cause;
  logic       pend_now;
  logic [1:0] pend_cause_now;
  logic       wait_done;

`ifdef HALT_STEP_EN
  logic              ret_step;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_load;

  // A step count of zero still runs the CPU for one cycle.
  always_comb begin
    step_load = (dbg_step_count == '0) ? STEP_W'(1) : dbg_step_count;
  end
`else
  logic unused_step;
  assign unused_step = ^{dbg_step, dbg_step_count};
`endif

  // Fold a halt request arriving this cycle into the pending flag so an exit on the same edge still honours it.
  always_comb begin
    pend_now       = pend | dbg_halt_req | ebreak;
    pend_cause_now = pend ? pend_cause : (dbg_halt_req ? CAUSE_DEBUG : CAUSE_EBREAK);
    wait_done      = mem_ack || (wait_cnt == WAIT_LAST);
  end

  // Moore outputs: halt gates the CPU clock whenever it is stalled on the bus or parked by the debugger.
  assign halt     = (state == MEM_WAIT) || (state == DBG_HALT);
  assign halted   = (state == DBG_HALT);
  assign mem_wait = (state == MEM_WAIT);

  // Main FSM with registered bus_error pulse and halt_cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= 8'd0;
      pend       <= 1'b0;
      pend_cause <= CAUSE_NONE;
      bus_error  <= 1'b0;
      halt_cause <= CAUSE_NONE;
`ifdef HALT_STEP_EN
      ret_step   <= 1'b0;
      step_cnt   <= '0;
`endif
    end else begin
      bus_error <= 1'b0;
      case (state)
        RUN: begin
          if (dbg_halt_req) begin
            state      <= DBG_HALT;
            halt_cause <= CAUSE_DEBUG;
          end else if (ebreak) begin
            state      <= DBG_HALT;
            halt_cause <= CAUSE_EBREAK;
          end else if (mem_req && !mem_ack) begin
            state      <= MEM_WAIT;
            wait_cnt   <= 8'd0;
            halt_cause <= CAUSE_MEM;
`ifdef HALT_STEP_EN
            ret_step   <= 1'b0;
`endif
          end
        end

        MEM_WAIT: begin
          if (wait_done) begin
            // An ack on the timeout cycle wins, so the error only fires without it.
            bus_error <= !mem_ack;
            wait_cnt  <= 8'd0;
            pend      <= 1'b0;
            if (pend_now) begin
              state      <= DBG_HALT;
              halt_cause <= pend_cause_now;
            end
`ifdef HALT_STEP_EN
            else if (ret_step) begin
              state <= STEP;
            end
`endif
            else begin
              state <= RUN;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (!pend && (dbg_halt_req || ebreak)) begin
              pend       <= 1'b1;
              pend_cause <= pend_cause_now;
            end
          end
        end

        DBG_HALT: begin
          if (dbg_resume) begin
            state      <= RUN;
            halt_cause <= CAUSE_NONE;
          end
`ifdef HALT_STEP_EN
          else if (dbg_step) begin
            state    <= STEP;
            step_cnt <= step_load;
          end
`endif
        end

`ifdef HALT_STEP_EN
        STEP: begin
          if (dbg_halt_req) begin
            state      <= DBG_HALT;
            halt_cause <= CAUSE_DEBUG;
            step_cnt   <= '0;
          end else if (ebreak) begin
            state      <= DBG_HALT;
            halt_cause <= CAUSE_EBREAK;
            step_cnt   <= '0;
          end else if (mem_req && !mem_ack) begin
            // The stalled cycle has not retired, so the step count stays frozen.
            state      <= MEM_WAIT;
            wait_cnt   <= 8'd0;
            halt_cause <= CAUSE_MEM;
            ret_step   <= 1'b1;
          end else if (step_cnt == STEP_W'(1)) begin
            state      <= DBG_HALT;
            halt_cause <= CAUSE_DEBUG;
            step_cnt   <= '0;
          end else begin
            step_cnt <= step_cnt - STEP_W'(1);
          end
        end
`endif

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_controller.sv
// Bench for halt_controller: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_halt_controller;

  localparam int TO = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req;
  logic          mem_ack;
  logic          dbg_halt_req;
  logic          dbg_resume;
  logic          dbg_step;
  logic [SW-1:0] dbg_step_count;
  logic          ebreak;
  logic          halt;
  logic          halted;
  logic          mem_wait;
  logic          bus_error;
  logic [1:0]    halt_cause;

  halt_controller #(.TIMEOUT_CYCLES(TO), .STEP_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume     (dbg_resume),
    .dbg_step       (dbg_step),
    .dbg_step_count (dbg_step_count),
    .ebreak         (ebreak),
    .halt           (halt),
    .halted         (halted),
    .mem_wait       (mem_wait),
    .bus_error      (bus_error),
    .halt_cause     (halt_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: activity mode plus elapsed-cycle bookkeeping.
  localparam int MD_RUN  = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_HALT = 2;
  localparam int MD_STEP = 3;

  int     m_mode;
  int     m_cause;
  int     m_berr;
  int     m_pend;        // 0: nothing pending, else the cause code to report
  int     m_back_step;
  int     m_step_budget;
  int     m_step_done;
  longint m_cyc = 0;
  longint m_wait_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode        = MD_RUN;
    m_cause       = 0;
    m_berr        = 0;
    m_pend        = 0;
    m_back_step   = 0;
    m_step_budget = 0;
    m_step_done   = 0;
  endtask

  task automatic model_edge();
    int nm;
    nm     = m_mode;
    m_berr = 0;
    m_cyc++;
    case (m_mode)
      MD_RUN: begin
        if (dbg_halt_req) begin nm = MD_HALT; m_cause = 2; end
        else if (ebreak) begin nm = MD_HALT; m_cause = 3; end
        else if (mem_req && !mem_ack) begin
          nm = MD_WAIT; m_cause = 1; m_wait_start = m_cyc; m_back_step = 0;
        end
      end
      MD_WAIT: begin
        if (m_pend == 0) m_pend = dbg_halt_req ? 2 : (ebreak ? 3 : 0);
        if (mem_ack || (m_cyc - m_wait_start) == longint'(TO)) begin
          if (!mem_ack) m_berr = 1;
          if (m_pend != 0) begin nm = MD_HALT; m_cause = m_pend; m_pend = 0; end
          else nm = (m_back_step != 0) ? MD_STEP : MD_RUN;
        end
      end
      MD_HALT: begin
        if (dbg_resume) begin nm = MD_RUN; m_cause = 0; end
`ifdef HALT_STEP_EN
        else if (dbg_step) begin
          nm = MD_STEP;
          m_step_budget = (int'(dbg_step_count) > 1) ? int'(dbg_step_count) : 1;
          m_step_done = 0;
        end
`endif
      end
      default: begin
        if (dbg_halt_req) begin nm = MD_HALT; m_cause = 2; end
        else if (ebreak) begin nm = MD_HALT; m_cause = 3; end
        else if (mem_req && !mem_ack) begin
          nm = MD_WAIT; m_cause = 1; m_wait_start = m_cyc; m_back_step = 1;
        end else begin
          m_step_done++;
          if (m_step_done == m_step_budget) begin nm = MD_HALT; m_cause = 2; end
        end
      end
    endcase
    m_mode = nm;
  endtask

  task automatic compare_all();
    chk("halt",       32'(halt),       32'(m_mode == MD_WAIT || m_mode == MD_HALT));
    chk("halted",     32'(halted),     32'(m_mode == MD_HALT));
    chk("mem_wait",   32'(mem_wait),   32'(m_mode == MD_WAIT));
    chk("bus_error",  32'(bus_error),  32'(m_berr));
    chk("halt_cause", 32'(halt_cause), 32'(m_cause));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called 1 time unit after an edge; reset rises and falls between edges.
  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    mem_req = 1'b0; mem_ack = 1'b0; dbg_halt_req = 1'b0; dbg_resume = 1'b0;
    dbg_step = 1'b0; dbg_step_count = '0; ebreak = 1'b0;
  endtask

  initial begin
    int n;
    int low;
    int ack_mode;
    reset = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    chk("rst_halt", 32'(halt), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_mem_wait", 32'(mem_wait), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_cause", 32'(halt_cause), 0);
    #10;
    reset = 1'b0;

    // Bus stall acknowledged on the third wait edge.
    mem_req = 1'b1; mem_ack = 1'b0;
    cyc();
    mem_req = 1'b0;
    n = int'(halt);
    chk("memw_cause", 32'(halt_cause), 1);
    cyc(); n += int'(halt);
    cyc(); n += int'(halt);
    mem_ack = 1'b1;
    cyc();
    chk("memw_halt_cycles", 32'(n), 3);
    chk("memw_exit_halt", 32'(halt), 0);
    chk("memw_exit_cause", 32'(halt_cause), 1);
    // Request and ack together never stall.
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc();
    chk("memack_same_halt", 32'(halt), 0);
    idle_inputs();
    cyc();

    // Timeout with no ack.
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    n = 40;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (bus_error) begin n = i; break; end
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_halt", 32'(halt), 0);
    cyc();
    chk("timeout_single_pulse", 32'(bus_error), 0);

    // Debug halt requested during a stall.
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0; dbg_halt_req = 1'b1;
    cyc();
    dbg_halt_req = 1'b0;
    low = int'(!halt);
    cyc(); low += int'(!halt);
    mem_ack = 1'b1;
    cyc(); low += int'(!halt);
    mem_ack = 1'b0;
    chk("pend_halted", 32'(halted), 1);
    chk("pend_cause", 32'(halt_cause), 2);
    chk("pend_no_gap", 32'(low), 0);
    dbg_resume = 1'b1;
    cyc();
    dbg_resume = 1'b0;
    chk("resume_cause", 32'(halt_cause), 0);

    // EBREAK from RUN.
    ebreak = 1'b1;
    cyc();
    ebreak = 1'b0;
    chk("ebreak_cause", 32'(halt_cause), 3);
    dbg_resume = 1'b1;
    cyc();
    dbg_resume = 1'b0;

    // Async reset at wait count 5.
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_rst_mem_wait", 32'(mem_wait), 1);
    reset = 1'b1;
    #2;
    model_reset();
    chk("async_rst_halt", 32'(halt), 0);
    chk("async_rst_mem_wait", 32'(mem_wait), 0);
    chk("async_rst_cause", 32'(halt_cause), 0);
    reset = 1'b0;
    cyc();

`ifdef HALT_STEP_EN
    // Single-step lengths and resume priority.
    dbg_halt_req = 1'b1;
    cyc();
    dbg_halt_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dbg_step = 1'b1;
      dbg_step_count = (k == 0) ? SW'(3) : SW'(0);
      cyc();
      dbg_step = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (halted) break;
        n++;
        cyc();
      end
      chk((k == 0) ? "step3_cycles" : "step0_cycles", 32'(n), (k == 0) ? 3 : 1);
      chk("step_rehalted", 32'(halted), 1);
    end
    dbg_step = 1'b1; dbg_resume = 1'b1; dbg_step_count = SW'(2);
    cyc();
    idle_inputs();
    chk("resume_beats_step", 32'(halt), 0);
    chk("resume_beats_step_cause", 32'(halt_cause), 0);
`endif

    // Randomized traffic against the model.
    ack_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) ack_mode = int'($urandom_range(0, 2));
      mem_req = ($urandom_range(0, 99) < 35);
      case (ack_mode)
        0:       mem_ack = 1'($urandom_range(0, 1));
        1:       mem_ack = 1'b0;
        default: mem_ack = ($urandom_range(0, 3) != 0);
      endcase
      dbg_halt_req   = ($urandom_range(0, 99) < 4);
      ebreak         = ($urandom_range(0, 99) < 3);
      dbg_resume     = ($urandom_range(0, 99) < 12);
      dbg_step       = ($urandom_range(0, 99) < 20);
      dbg_step_count = SW'($urandom_range(0, 5));
      cyc();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/halt_controller.md
HALT_CONTROLLER -- requirements
Module: halt_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, halt cycles in MEM_WAIT before a bus access is abandoned; legal range 2..255.
REQ-002 Parameter STEP_W, 4, width of the debug step count.
REQ-003 Port clk, input, 1, free-running system clock; the same clock that drives the CPU clock gate, never gated.
REQ-004 Port reset, input, 1, reset, asynchronous, active-high.
REQ-005 Port mem_req, input, 1, CPU data-bus access issued this cycle (level).
REQ-006 Port mem_ack, input, 1, bus access complete (level, sampled on posedge clk).
REQ-007 Port dbg_halt_req, input, 1, debugger halt request.
REQ-008 Port dbg_resume, input, 1, debugger resume.
REQ-009 Port dbg_step, input, 1, debugger single-step request.
REQ-010 Port dbg_step_count, input, STEP_W, CPU cycles per step; 0 is treated as 1.
REQ-011 Port ebreak, input, 1, core decoded an EBREAK.
REQ-012 Port halt, output, 1, halt request to the CPU clock gate.
REQ-013 Port halted, output, 1, high only in state DBG_HALT.
REQ-014 Port mem_wait, output, 1, high only in state MEM_WAIT.
REQ-015 Port bus_error, output, 1, one-cycle pulse on bus timeout.
REQ-016 Port halt_cause, output, 2, reason for the last halt: 00 none, 01 memory, 10 debug, 11 ebreak.

Function
REQ-017 The FSM SHALL have states RUN, MEM_WAIT, DBG_HALT and STEP, with transitions on posedge clk.
REQ-018 All outputs SHALL be registered or decoded from state only (Moore), so halt asserts or deasserts exactly 1 clk after the causing input.
REQ-019 halt SHALL be 1 in MEM_WAIT and DBG_HALT and 0 in RUN and STEP.
REQ-020 RUN transitions, in priority order: dbg_halt_req -> DBG_HALT (cause 10); ebreak -> DBG_HALT (cause 11); mem_req&!mem_ack -> MEM_WAIT (cause 01); mem_req&mem_ack -> stay in RUN.
REQ-021 A 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each cycle in MEM_WAIT.
REQ-022 In MEM_WAIT, mem_ack SHALL return to the saved return state (RUN or STEP).
REQ-023 In MEM_WAIT, if the wait counter reaches TIMEOUT_CYCLES-1 without mem_ack, the block SHALL pulse bus_error for 1 cycle and return to the return state.
REQ-024 If mem_ack arrives in the same cycle as the timeout, the ack SHALL win and bus_error SHALL stay 0.
REQ-025 dbg_halt_req or ebreak seen in MEM_WAIT SHALL set a pending flag; on exit from MEM_WAIT a set flag SHALL send the FSM to DBG_HALT instead of the return state and clear the flag.
REQ-026 In DBG_HALT, dbg_resume SHALL go to RUN and set halt_cause to 00.
REQ-027 In DBG_HALT, dbg_step SHALL go to STEP and load the step counter with max(dbg_step_count,1); if dbg_resume and dbg_step are both high, dbg_resume wins.
REQ-028 In STEP, the step counter SHALL decrement each cycle; when it equals 1, the FSM SHALL return to DBG_HALT.
REQ-029 In STEP, mem_req&!mem_ack SHALL go to MEM_WAIT with return state STEP, and the step counter SHALL freeze while in MEM_WAIT.
REQ-030 In STEP, dbg_halt_req SHALL go to DBG_HALT immediately and discard the remaining step count.
REQ-031 halt_cause SHALL hold its value until the next halt entry or resume.

Reset
REQ-032 Asserting reset SHALL force, asynchronously and at any time (including mid-MEM_WAIT or mid-STEP): state RUN, halt 0, halted 0, mem_wait 0, bus_error 0, halt_cause 00, all counters 0, pending flag 0.
REQ-033 After reset deasserts, the first state change SHALL occur on the first posedge clk.

Configuration
REQ-034 With macro HALT_STEP_EN defined, the STEP state and step counter SHALL be present as specified.
REQ-035 Without HALT_STEP_EN, dbg_step and dbg_step_count SHALL be ignored, the STEP state and step counter SHALL not exist, and the return state SHALL always be RUN.

Verification
REQ-036 Reset mid-MEM_WAIT: assert reset at wait count 5 -> halt=0, mem_wait=0 and cause=00 immediately, without waiting for a clk edge.
REQ-037 Memory wait: mem_req=1, mem_ack=0, then mem_ack=1 after 3 cycles -> halt high for 3 cycles, cause=01, then RUN; also mem_req=mem_ack=1 together -> halt stays 0.
REQ-038 Timeout: TIMEOUT_CYCLES=16 and mem_ack never arrives -> bus_error pulses once, 16 cycles after entering MEM_WAIT, then halt=0.
REQ-039 Pending debug halt: dbg_halt_req during MEM_WAIT, then mem_ack -> DBG_HALT with halted=1, cause=10, and halt never drops low in between.
REQ-040 Step (HALT_STEP_EN): from DBG_HALT, dbg_step with count=3 -> halt=0 for exactly 3 cycles, then halted=1; count=0 -> exactly 1 cycle; dbg_resume and dbg_step together -> RUN.
